// File: rtl/tm4_sched.sv
// tm4_sched: raster-order TrueMotion 4x4 intra prediction over one 16x16 luma macroblock.
// Optional macro TM4_SCHED_OPEN_LOOP_EN: context is fed from predictions, RECON is skipped.
module tm4_sched #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [4*BLOCK_SIZE*BIT_WIDTH-1:0]          mb_top,
  input  logic [4*BLOCK_SIZE*BIT_WIDTH-1:0]          mb_left,
  input  logic [BIT_WIDTH-1:0]                       mb_top_left,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       pred_valid,
  input  logic                                       pred_ready,
  output logic [3:0]                                 pred_idx,
  output logic [BLOCK_SIZE*BLOCK_SIZE*BIT_WIDTH-1:0] pred_dst,
  input  logic                                       recon_valid,
  output logic                                       recon_ready,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*BIT_WIDTH-1:0] recon_data
);
  localparam int MB_PX  = 4 * BLOCK_SIZE;
  localparam int BLK_PX = BLOCK_SIZE * BLOCK_SIZE;
  localparam int TW     = BIT_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, CALC, OFFER, RECON, DONE} state_t;

  state_t                        state_reg, state_next;
  logic [3:0]                    k_reg;
  logic [MB_PX*BIT_WIDTH-1:0]    top_buf_reg;
  logic [MB_PX*BIT_WIDTH-1:0]    left_buf_reg;
  logic [BIT_WIDTH-1:0]          tl_buf_reg;
  logic [BLOCK_SIZE*BIT_WIDTH-1:0] col_buf_reg;
  logic [BIT_WIDTH-1:0]          corner_reg;
  logic [BLK_PX*BIT_WIDTH-1:0]   pred_dst_reg, pred_dst_next;
  logic [BLOCK_SIZE*BIT_WIDTH-1:0] nb_top, nb_left;
  logic [BIT_WIDTH-1:0]          nb_tl;
  logic [BLK_PX*BIT_WIDTH-1:0]   upd_data;
  logic                          ctx_upd;
  logic [1:0]                    bx, by;

  assign bx = k_reg[1:0];
  assign by = k_reg[3:2];

  genvar gi;
  for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_nb
    assign nb_top[gi*BIT_WIDTH +: BIT_WIDTH] = top_buf_reg[int'({bx, 2'(gi)})*BIT_WIDTH +: BIT_WIDTH];
    assign nb_left[gi*BIT_WIDTH +: BIT_WIDTH] = (bx == 2'd0)
        ? left_buf_reg[int'({by, 2'(gi)})*BIT_WIDTH +: BIT_WIDTH]
        : col_buf_reg[gi*BIT_WIDTH +: BIT_WIDTH];
  end

  // Left-column blocks take the corner from the MB border; others from the running context.
  always_comb begin
    nb_tl = corner_reg;
    if (bx == 2'd0) begin
      nb_tl = (by == 2'd0) ? tl_buf_reg
                           : left_buf_reg[int'({by - 2'd1, 2'd3})*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  for (gi = 0; gi < BLK_PX; gi++) begin : g_pix
    logic signed [TW-1:0] temp;
    assign temp = $signed({2'b00, nb_top[(gi%BLOCK_SIZE)*BIT_WIDTH +: BIT_WIDTH]})
                + $signed({2'b00, nb_left[(gi/BLOCK_SIZE)*BIT_WIDTH +: BIT_WIDTH]})
                - $signed({2'b00, nb_tl});
    assign pred_dst_next[gi*BIT_WIDTH +: BIT_WIDTH] =
        temp[TW-1] ? '0 : ((|temp[TW-2:BIT_WIDTH]) ? '1 : temp[BIT_WIDTH-1:0]);
  end

  always_comb begin
    state_next = state_reg;
    ctx_upd    = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = CALC;
      CALC:  state_next = OFFER;
      OFFER: if (pred_ready) begin
`ifdef TM4_SCHED_OPEN_LOOP_EN
        ctx_upd    = 1'b1;
        state_next = (k_reg == 4'd15) ? DONE : CALC;
`else
        state_next = RECON;
`endif
      end
`ifndef TM4_SCHED_OPEN_LOOP_EN
      RECON: if (recon_valid) begin
        ctx_upd    = 1'b1;
        state_next = (k_reg == 4'd15) ? DONE : CALC;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef TM4_SCHED_OPEN_LOOP_EN
  logic unused_recon;
  assign unused_recon = recon_valid ^ (^recon_data);
  assign upd_data     = pred_dst_reg;
  assign recon_ready  = 1'b0;
`else
  assign upd_data     = recon_data;
  assign recon_ready  = (state_reg == RECON);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      pred_dst_reg <= '0;
      top_buf_reg  <= '0;
      left_buf_reg <= '0;
      tl_buf_reg   <= '0;
      col_buf_reg  <= '0;
      corner_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        k_reg        <= '0;
        top_buf_reg  <= mb_top;
        left_buf_reg <= mb_left;
        tl_buf_reg   <= mb_top_left;
      end
      if (state_reg == CALC) pred_dst_reg <= pred_dst_next;
      // k wraps 15 -> 0 on the last accept, so IDLE always shows index 0.
      if (ctx_upd) begin
        k_reg      <= k_reg + 4'd1;
        corner_reg <= top_buf_reg[int'({bx, 2'd3})*BIT_WIDTH +: BIT_WIDTH];
        for (int n = 0; n < BLOCK_SIZE; n++) begin
          top_buf_reg[int'({bx, 2'(n)})*BIT_WIDTH +: BIT_WIDTH] <=
              upd_data[(3*BLOCK_SIZE+n)*BIT_WIDTH +: BIT_WIDTH];
          col_buf_reg[n*BIT_WIDTH +: BIT_WIDTH] <=
              upd_data[(n*BLOCK_SIZE+3)*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

  assign busy       = (state_reg == CALC) || (state_reg == OFFER) || (state_reg == RECON);
  assign done       = (state_reg == DONE);
  assign pred_valid = (state_reg == OFFER);
  assign pred_idx   = k_reg;
  assign pred_dst   = pred_dst_reg;

endmodule

// File: tb/tb_tm4_sched.sv
// Bench for tm4_sched: table of border vectors plus directed stall, noise and reset-abort runs.
`timescale 1ns/1ps
module tb_tm4_sched;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] mb_top = '0, mb_left = '0;
  logic [7:0]   mb_top_left = '0;
  logic         busy, done, pred_valid, recon_ready;
  logic         pred_ready = 1'b1, recon_valid = 1'b0;
  logic [3:0]   pred_idx;
  logic [127:0] pred_dst, recon_data;
  logic [7:0]   rxor = '0;
  int           checks = 0, failures = 0;
  logic [7:0]   img [17][17];

  typedef struct {
    logic [127:0] top;
    logic [127:0] left;
    logic [7:0]   tl;
    logic [7:0]   xr;
    logic [127:0] blk0;
    int           cyc;
  } vec_t;

  always #5 clk = ~clk;

  // Reconstruction echoes the prediction, optionally perturbed so the context path is visible.
  assign recon_data = pred_dst ^ {16{rxor}};

  tm4_sched #(.BIT_WIDTH(8), .BLOCK_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mb_top(mb_top), .mb_left(mb_left), .mb_top_left(mb_top_left),
    .busy(busy), .done(done),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_idx(pred_idx), .pred_dst(pred_dst),
    .recon_valid(recon_valid), .recon_ready(recon_ready), .recon_data(recon_data)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Golden model: a 17x17 picture (border row/col 0) filled in as reconstructions arrive.
  task automatic init_img(input logic [127:0] t, input logic [127:0] l, input logic [7:0] tl);
    img[0][0] = tl;
    for (int n = 0; n < 16; n++) begin
      img[0][n+1] = t[8*n +: 8];
      img[n+1][0] = l[8*n +: 8];
    end
  endtask

  function automatic logic [127:0] model_pred(input int k);
    int by = k / 4;
    int bx = k % 4;
    int v;
    logic [127:0] r = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        v = int'(img[4*by][4*bx+1+i]) + int'(img[4*by+1+j][4*bx]) - int'(img[4*by][4*bx]);
        if (v < 0) v = 0;
        else if (v > 255) v = 255;
        r[8*(4*j+i) +: 8] = 8'(v);
      end
    end
    return r;
  endfunction

  task automatic model_recon(input int k, input logic [127:0] d);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        img[4*(k/4)+1+j][4*(k%4)+1+i] = d[8*(4*j+i) +: 8];
  endtask

  task automatic run_mb(input string label, input logic [127:0] t, input logic [127:0] l,
                        input logic [7:0] tl, input logic [7:0] xr,
                        input int stall_k, input int stall_n, input int gap_k, input int gap_n,
                        input bit noise, input int abort_k,
                        output int cycles, output logic [127:0] blk0);
    int k = 0, cyc = 0, stall = 0, gap = 0;
    bit fresh = 1'b1, fin = 1'b0;
    logic [127:0] exp;
    init_img(t, l, tl);
    rxor = xr;
    cycles = -1;
    blk0 = '0;
    @(negedge clk);
    mb_top = t; mb_left = l; mb_top_left = tl;
    start = 1'b1; pred_ready = 1'b1; recon_valid = noise;
    @(posedge clk);
    #1;
    if (noise) begin
      mb_top = ~t; mb_left = ~l; mb_top_left = ~tl;
    end else begin
      start = 1'b0;
    end
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_after_start", {busy, pred_valid}, 2'b10);
      if (cyc == 2) chk("valid_two_after_start", pred_valid, 1'b1);
      chk("valid_ready_exclusive", pred_valid & recon_ready, 1'b0);
      exp = model_pred(k);
      if (done) begin
        cycles = cyc;
        chk("busy_low_at_done", busy, 1'b0);
        start = 1'b0;
        fin = 1'b1;
      end else if (pred_valid) begin
        if (fresh) begin
          chk($sformatf("pred_idx k=%0d", k), pred_idx, 128'(k));
          chk($sformatf("pred_dst k=%0d", k), pred_dst, exp);
          if (k == 0) blk0 = pred_dst;
          fresh = 1'b0;
          stall = (k == stall_k) ? stall_n : 0;
          gap   = (k == gap_k) ? gap_n : 0;
        end
        if (k == abort_k) begin
          rst_n = 1'b0;
          #1;
          chk("abort_ctrl_zero", {busy, done, pred_valid, recon_ready, pred_idx}, '0);
          chk("abort_dst_zero", pred_dst, '0);
          @(negedge clk);
          rst_n = 1'b1;
          fin = 1'b1;
        end else if (stall > 0) begin
          pred_ready = 1'b0;
          stall--;
          chk("stall_hold_idx", pred_idx, 128'(k));
          chk("stall_hold_dst", pred_dst, exp);
        end else begin
          pred_ready = 1'b1;
        end
      end else if (recon_ready) begin
        pred_ready = 1'b1;
        if (gap > 0) begin
          recon_valid = 1'b0;
          gap--;
        end else begin
          recon_valid = 1'b1;
          model_recon(k, exp ^ {16{xr}});
          k++;
          fresh = 1'b1;
        end
      end else begin
        pred_ready  = 1'b1;
        recon_valid = noise;
      end
    end
    start = 1'b0;
    recon_valid = 1'b0;
    pred_ready = 1'b1;
    if (abort_k < 0) begin
      chk("done_seen", fin, 1'b1);
      chk("blocks_accepted", 128'(k), 128'd16);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
    end
    $display("mb %s: blocks=%0d cycles=%0d", label, k, cycles);
  endtask

  localparam logic [127:0] RAMP_TOP  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] RAMP_LEFT = 128'hf0e0d0c0_b0a09080_70605040_30201000;
  localparam logic [127:0] RAMP_BLK0 = 128'h33323130_23222120_13121110_03020100;

  initial begin
    vec_t vecs [5];
    int cyc;
    logic [127:0] b0;

    vecs[0] = '{{16{8'h80}}, {16{8'h80}}, 8'h80, 8'h00, {16{8'h80}}, 49};
    vecs[1] = '{{16{8'hFF}}, {16{8'hFF}}, 8'h00, 8'h00, {16{8'hFF}}, 49};
    vecs[2] = '{{16{8'h00}}, {16{8'h00}}, 8'hFF, 8'h00, {16{8'h00}}, 49};
    vecs[3] = '{RAMP_TOP, RAMP_LEFT, 8'h00, 8'h00, RAMP_BLK0, 49};
    vecs[4] = '{RAMP_TOP, RAMP_LEFT, 8'h00, 8'h5A, RAMP_BLK0, 49};

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, pred_valid, recon_ready, pred_idx}, '0);
    chk("reset_dst", pred_dst, '0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_mb($sformatf("vec%0d", v), vecs[v].top, vecs[v].left, vecs[v].tl, vecs[v].xr,
             -1, 0, -1, 0, 1'b0, -1, cyc, b0);
      chk($sformatf("blk0 vec%0d", v), b0, vecs[v].blk0);
      chk($sformatf("done_cycles vec%0d", v), 128'(cyc), 128'(vecs[v].cyc));
    end

    // Downstream stall of 10 cycles at k=3 pushes done out by 10.
    run_mb("stall", RAMP_TOP, RAMP_LEFT, 8'h00, 8'h00, 3, 10, -1, 0, 1'b0, -1, cyc, b0);
    chk("done_cycles stall", 128'(cyc), 128'd59);

    // Late reconstruction at k=6 (4 idle cycles in RECON).
    run_mb("recon_gap", RAMP_TOP, RAMP_LEFT, 8'h00, 8'h5A, -1, 0, 6, 4, 1'b0, -1, cyc, b0);
    chk("done_cycles recon_gap", 128'(cyc), 128'd53);

    // start held high and borders changed while busy; recon_valid high during OFFER.
    run_mb("noise", RAMP_TOP, RAMP_LEFT, 8'h00, 8'h00, -1, 0, -1, 0, 1'b1, -1, cyc, b0);
    chk("done_cycles noise", 128'(cyc), 128'd49);

    // Reset in the middle of block 7, then a fresh macroblock from k=0.
    run_mb("abort", RAMP_TOP, RAMP_LEFT, 8'h00, 8'h00, -1, 0, -1, 0, 1'b0, 7, cyc, b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_after_abort", {busy, done, pred_valid, recon_ready}, 4'b0000);
    end
    run_mb("restart", {16{8'h80}}, {16{8'h80}}, 8'h80, 8'h00, -1, 0, -1, 0, 1'b0, -1, cyc, b0);
    chk("done_cycles restart", 128'(cyc), 128'd49);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
